dmem_resp: RTL and testbench

- Data-memory responder on the memory-stage side of the pipeline's data port.
- Accepts word-address, write-data and write-enable from the M stage and returns registered read data for the W stage.
- Decodes a small MMIO window containing a console TX FIFO with a valid/ready drain port, a status register, a halt/exit register and an optional cycle counter.
- Backing RAM is an internal word array.

---
 rtl/dmem_resp.sv | 156 +++++++++++++++
 tb/tb_dmem_resp.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: word RAM plus an MMIO page (console TX FIFO, STATUS, HALT, CYCLE).
// Defining DMEM_CYCLE_CNT_EN builds the free-running cycle counter behind the CYCLE register.
module dmem_resp #(
    parameter int          ADDR_W     = 13,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] IO_PAGE    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemWriteM,
    input  logic [31:0] DataAddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataW,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [13:0] OFF_TX     = 14'd0;
    localparam logic [13:0] OFF_STATUS = 14'd1;
    localparam logic [13:0] OFF_CYCLE  = 14'd2;
    localparam logic [13:0] OFF_HALT   = 14'd3;

    logic [31:0]        ram [0:(2**ADDR_W)-1];
    logic [7:0]         fifo_mem [0:FIFO_DEPTH-1];
    logic [31:0]        ram_rd_reg;
    logic [31:0]        io_rd_reg;
    logic [31:0]        io_rd_next;
    logic               io_sel_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               overflow_reg;
    logic               halt_reg;
    logic [31:0]        exit_code_reg;
    logic [31:0]        cycle_val;

    logic               io;
    logic [13:0]        word_off;
    logic [ADDR_W-1:0]  ram_idx;
    logic               io_wr;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               ovf_set;
    logic               ovf_clr;
    logic               empty;
    logic               full;
    logic               unused_addr;

    assign io          = (DataAddrM[31:16] == IO_PAGE);
    assign word_off    = DataAddrM[15:2];
    assign ram_idx     = DataAddrM[ADDR_W+1:2];
    assign unused_addr = &{1'b0, DataAddrM[1:0]};
    assign io_wr       = MemWriteM & io;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == DEPTH_C);
    assign tx_valid = ~empty;
    assign tx_data  = fifo_mem[rd_ptr_reg];
    assign pop      = tx_valid & tx_ready;
    assign push_req = io_wr & (word_off == OFF_TX);
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push_ok  = push_req & (~full | pop);
    assign ovf_set  = push_req & ~push_ok;
    assign ovf_clr  = io_wr & (word_off == OFF_STATUS) & WriteDataM[2];

    assign halt      = halt_reg;
    assign exit_code = exit_code_reg;

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_reg;

    always_ff @(posedge clk) begin
        if (rst)
            cycle_reg <= '0;
        else if (io_wr && word_off == OFF_CYCLE)
            cycle_reg <= WriteDataM;
        else
            cycle_reg <= cycle_reg + 32'd1;
    end

    assign cycle_val = cycle_reg;
`else
    assign cycle_val = '0;
`endif

    // Read-first RAM port; the write is gated so that reset cancels it.
    always_ff @(posedge clk) begin
        if (!rst && MemWriteM && !io)
            ram[ram_idx] <= WriteDataM;
        ram_rd_reg <= ram[ram_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            fifo_mem[wr_ptr_reg] <= WriteDataM[7:0];
    end

    always_comb begin
        io_rd_next = '0;
        case (word_off)
            OFF_STATUS: io_rd_next = {29'b0, overflow_reg, full, empty};
            OFF_CYCLE:  io_rd_next = cycle_val;
            OFF_HALT:   io_rd_next = exit_code_reg;
            default:    io_rd_next = '0;
        endcase
    end

    // ReadDataW resets to 0 by selecting the cleared MMIO path over the unresettable RAM output.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_sel_reg <= 1'b1;
            io_rd_reg  <= '0;
        end else begin
            io_sel_reg <= io;
            io_rd_reg  <= io_rd_next;
        end
    end

    assign ReadDataW = io_sel_reg ? io_rd_reg : ram_rd_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            halt_reg      <= 1'b0;
            exit_code_reg <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (ovf_set)
                overflow_reg <= 1'b1;
            else if (ovf_clr)
                overflow_reg <= 1'b0;
            if (io_wr && word_off == OFF_HALT && !halt_reg) begin
                halt_reg      <= 1'b1;
                exit_code_reg <= WriteDataM;
            end
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed scenarios plus a randomized run against a queue/array model.
// Define DMEM_CYCLE_CNT_EN for both bench and RTL to exercise the cycle counter.
module tb_dmem_resp;
    localparam int ADDR_W = 13;
    localparam int DEPTH  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemWriteM = 1'b0;
    logic [31:0] DataAddrM = '0;
    logic [31:0] WriteDataM = '0;
    logic [31:0] ReadDataW;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        halt;
    logic [31:0] exit_code;

    int total = 0;
    int bad   = 0;

    dmem_resp #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .IO_PAGE(16'hFFFF)) dut (
        .clk(clk), .rst(rst), .MemWriteM(MemWriteM), .DataAddrM(DataAddrM),
        .WriteDataM(WriteDataM), .ReadDataW(ReadDataW), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .halt(halt), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             output logic [31:0] rd);
        MemWriteM  = we;
        DataAddrM  = addr;
        WriteDataM = data;
        cyc();
        rd = ReadDataW;
        MemWriteM = 1'b0;
        $display("%s addr=%h wdata=%h rdata=%h", we ? "wr" : "rd", addr, data, rd);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        MemWriteM = 1'b0;
        DataAddrM = '0;
        tx_ready = 1'b0;
        repeat (2) cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (ReadDataW !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", ReadDataW); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b want=0", tx_valid); end
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL reset_halt got=%b want=0", halt); end
        total++; if (exit_code !== 32'h0) begin bad++; $display("FAIL reset_exit got=%h want=0", exit_code); end
    endtask

    task automatic test_ram();
        logic [31:0] rd;
        do_access(1'b1, 32'h40, 32'h0BADF00D, rd);
        do_access(1'b1, 32'h40, 32'hDEADBEEF, rd);
        total++; if (rd !== 32'h0BADF00D) begin bad++; $display("FAIL ram_read_first got=%h want=0badf00d", rd); end
        do_access(1'b0, 32'h40, 32'h0, rd);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_read got=%h want=deadbeef", rd); end
        do_access(1'b1, 32'h00008000, 32'h11, rd);
        do_access(1'b0, 32'h00000000, 32'h0, rd);
        total++; if (rd !== 32'h11) begin bad++; $display("FAIL ram_alias got=%h want=11", rd); end
    endtask

    task automatic test_console();
        logic [31:0] rd;
        apply_reset();
        for (int i = 0; i < 3; i++) do_access(1'b1, 32'hFFFF0000, 32'h41 + i, rd);
        do_access(1'b0, 32'hFFFF0004, 32'h0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL console_status got=%h want=0", rd); end
        for (int i = 0; i < 2; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin bad++; $display("FAIL console_hold got=%b/%h want=1/41", tx_valid, tx_data); end
            cyc();
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin bad++; $display("FAIL console_drain got=%b/%h want=1/%h", tx_valid, tx_data, 8'(8'h41 + i)); end
            $display("pop byte=%h", tx_data);
            cyc();
        end
        tx_ready = 1'b0;
        do_access(1'b0, 32'hFFFF0004, 32'h0, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL console_empty got=%h want=1", rd); end
        // push and pop requested together on an empty FIFO: push only
        tx_ready = 1'b1;
        do_access(1'b1, 32'hFFFF0000, 32'h5A, rd);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) begin bad++; $display("FAIL empty_push_pop got=%b/%h want=1/5a", tx_valid, tx_data); end
        cyc();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL empty_push_pop_drain got=%b want=0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] rd;
        logic [7:0]  expq[$];
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            do_access(1'b1, 32'hFFFF0000, 32'h30 + i, rd);
            if (i < DEPTH) expq.push_back(8'(8'h30 + i));
        end
        do_access(1'b0, 32'hFFFF0004, 32'h0, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL ovf_status got=%h want=6", rd); end
        do_access(1'b1, 32'hFFFF0004, 32'h4, rd);
        do_access(1'b0, 32'hFFFF0004, 32'h0, rd);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL ovf_clear got=%h want=2", rd); end
        tx_ready = 1'b1;
        do_access(1'b1, 32'hFFFF0000, 32'h50, rd);
        tx_ready = 1'b0;
        void'(expq.pop_front());
        expq.push_back(8'h50);
        do_access(1'b0, 32'hFFFF0004, 32'h0, rd);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL full_push_pop got=%h want=2", rd); end
        tx_ready = 1'b1;
        while (expq.size() > 0) begin
            total++; if (tx_valid !== 1'b1 || tx_data !== expq[0]) begin bad++; $display("FAIL ovf_drain got=%b/%h want=1/%h", tx_valid, tx_data, expq[0]); end
            $display("pop byte=%h", tx_data);
            void'(expq.pop_front());
            cyc();
        end
        tx_ready = 1'b0;
        do_access(1'b0, 32'hFFFF0004, 32'h0, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL ovf_final got=%h want=1", rd); end
    endtask

    task automatic test_halt();
        logic [31:0] rd;
        do_access(1'b1, 32'h40, 32'hCAFEF00D, rd);
        do_access(1'b1, 32'hFFFF000C, 32'h2A, rd);
        do_access(1'b1, 32'hFFFF000C, 32'h7, rd);
        total++; if (halt !== 1'b1 || exit_code !== 32'h2A) begin bad++; $display("FAIL halt_first got=%b/%h want=1/2a", halt, exit_code); end
        do_access(1'b0, 32'hFFFF000C, 32'h0, rd);
        total++; if (rd !== 32'h2A) begin bad++; $display("FAIL halt_read got=%h want=2a", rd); end
        do_access(1'b1, 32'hFFFF0000, 32'h77, rd);
        // writes presented while reset is high are cancelled
        rst = 1'b1;
        MemWriteM = 1'b1; DataAddrM = 32'h40; WriteDataM = 32'h12345678;
        cyc();
        MemWriteM = 1'b1; DataAddrM = 32'hFFFF0000; WriteDataM = 32'h99;
        cyc();
        MemWriteM = 1'b0; rst = 1'b0;
        total++; if (halt !== 1'b0 || exit_code !== 32'h0) begin bad++; $display("FAIL halt_reset got=%b/%h want=0/0", halt, exit_code); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_flush got=%b want=0", tx_valid); end
        do_access(1'b0, 32'h40, 32'h0, rd);
        total++; if (rd !== 32'hCAFEF00D) begin bad++; $display("FAIL ram_keep got=%h want=cafef00d", rd); end
    endtask

    task automatic test_cycle();
        logic [31:0] rd;
        apply_reset();
        repeat (10) cyc();
        do_access(1'b0, 32'hFFFF0008, 32'h0, rd);
`ifdef DMEM_CYCLE_CNT_EN
        total++; if (rd !== 32'd10) begin bad++; $display("FAIL cycle_count got=%h want=a", rd); end
        do_access(1'b1, 32'hFFFF0008, 32'hFFFFFFFE, rd);
        repeat (2) cyc();
        do_access(1'b0, 32'hFFFF0008, 32'h0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cycle_wrap got=%h want=0", rd); end
`else
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cycle_absent got=%h want=0", rd); end
        do_access(1'b1, 32'hFFFF0008, 32'h1234, rd);
        do_access(1'b0, 32'hFFFF0008, 32'h0, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL cycle_absent_wr got=%h want=0", rd); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] ram_m [16];
        logic [7:0]  q[$];
        logic        ovf_m;
        logic [31:0] rd, exp_rd, addr, data;
        int          op, idx;
        logic        do_pop, do_push, ok;
        apply_reset();
        ovf_m = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ram_m[i] = $urandom;
            do_access(1'b1, 32'(i) << 2, ram_m[i], rd);
        end
        for (int n = 0; n < 300; n++) begin
            op = $urandom_range(0, 3);
            tx_ready = ($urandom_range(0, 2) == 0);
            total++; if (tx_valid !== (q.size() != 0)) begin bad++; $display("FAIL rand_valid n=%0d got=%b want=%b", n, tx_valid, q.size() != 0); end
            if (q.size() != 0) begin
                total++; if (tx_data !== q[0]) begin bad++; $display("FAIL rand_data n=%0d got=%h want=%h", n, tx_data, q[0]); end
            end
            data = $urandom;
            idx  = $urandom_range(0, 15);
            addr = $urandom;
            addr[ADDR_W+1:2] = ADDR_W'(idx);
            if (addr[31:16] == 16'hFFFF) addr[31] = 1'b0;
            do_pop  = (q.size() != 0) && tx_ready;
            do_push = 1'b0;
            case (op)
                0: begin exp_rd = ram_m[idx]; ram_m[idx] = data; do_access(1'b1, addr, data, rd); end
                1: begin exp_rd = ram_m[idx]; do_access(1'b0, addr, data, rd); end
                2: begin
                    exp_rd = 32'h0; do_push = 1'b1;
                    do_access(1'b1, 32'hFFFF0000 | 32'($urandom_range(0, 3)), data, rd);
                end
                default: begin
                    exp_rd = {29'b0, ovf_m, q.size() == DEPTH, q.size() == 0};
                    if (data[0]) begin
                        do_access(1'b1, 32'hFFFF0004, 32'h4, rd);
                        ovf_m = 1'b0;
                    end else begin
                        do_access(1'b0, 32'hFFFF0004, 32'h0, rd);
                    end
                end
            endcase
            ok = do_push && (q.size() < DEPTH || do_pop);
            if (do_pop) void'(q.pop_front());
            if (ok) q.push_back(data[7:0]);
            if (do_push && !ok) ovf_m = 1'b1;
            total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata n=%0d op=%0d got=%h want=%h", n, op, rd, exp_rd); end
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ram();
        test_console();
        test_overflow();
        test_halt();
        test_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
